// File: rtl/bw_pixel_source.sv
// Thresholds a valid/ready stream of 8-bit grayscale pixels to one bit per pixel and emits it
// in raster order with position and line/frame boundary flags, one cycle after each transfer.
module bw_pixel_source #(
    parameter int unsigned WIDTH      = 640,
    parameter int unsigned HEIGHT     = 480,
    parameter logic [7:0]  THRESH_RST = 8'd128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       thresh_ld,
    input  logic [7:0] thresh_in,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic       d_out,
    output logic       ena,
    output logic [9:0] x_pos,
    output logic [8:0] y_pos,
    output logic       line_end,
    output logic       frame_end,
    output logic       busy
);

    localparam logic [9:0] ColLast = 10'(WIDTH - 1);
    localparam logic [8:0] RowLast = 9'(HEIGHT - 1);

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

    state_e     state_q;
    logic [7:0] thresh_q;
    logic [9:0] col_q;
    logic [8:0] row_q;
    logic       d_out_q;
    logic       ena_q;
    logic [9:0] x_pos_q;
    logic [8:0] y_pos_q;
    logic       line_end_q;
    logic       frame_end_q;

    logic transfer;
    logic last_col;
    logic last_pix;

    // Ready depends only on state so the upstream producer never sees a combinational loop.
    assign pix_ready = (state_q == StStream);
    assign busy      = (state_q != StIdle);
    assign transfer  = pix_valid && pix_ready;
    assign last_col  = (col_q == ColLast);
    assign last_pix  = last_col && (row_q == RowLast);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            thresh_q    <= THRESH_RST;
            col_q       <= '0;
            row_q       <= '0;
            d_out_q     <= 1'b0;
            ena_q       <= 1'b0;
            x_pos_q     <= '0;
            y_pos_q     <= '0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            ena_q       <= transfer;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (thresh_ld) begin
                        thresh_q <= thresh_in;
                    end
                    if (start) begin
                        col_q   <= '0;
                        row_q   <= '0;
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    if (transfer) begin
                        d_out_q     <= (pix_in >= thresh_q);
                        x_pos_q     <= col_q;
                        y_pos_q     <= row_q;
                        line_end_q  <= last_col;
                        frame_end_q <= last_pix;
                        if (last_col) begin
                            col_q <= '0;
                            row_q <= row_q + 9'd1;
                        end else begin
                            col_q <= col_q + 10'd1;
                        end
                        if (last_pix) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign d_out     = d_out_q;
    assign ena       = ena_q;
    assign x_pos     = x_pos_q;
    assign y_pos     = y_pos_q;
    assign line_end  = line_end_q;
    assign frame_end = frame_end_q;

endmodule

// File: tb/tb_bw_pixel_source.sv
// Randomized scoreboard bench for bw_pixel_source on a 4x3 frame: a driver feeds pixels and
// pushes expected outputs from a frame-position model; a monitor pops and compares on ena.
module tb_bw_pixel_source;

    localparam int W = 4;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       thresh_ld = 1'b0;
    logic [7:0] thresh_in = 8'd0;
    logic [7:0] pix_in = 8'd0;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    logic       d_out;
    logic       ena;
    logic [9:0] x_pos;
    logic [8:0] y_pos;
    logic       line_end;
    logic       frame_end;
    logic       busy;

    bw_pixel_source #(
        .WIDTH(W),
        .HEIGHT(H),
        .THRESH_RST(8'd128)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .thresh_ld(thresh_ld),
        .thresh_in(thresh_in),
        .pix_in(pix_in),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .d_out(d_out),
        .ena(ena),
        .x_pos(x_pos),
        .y_pos(y_pos),
        .line_end(line_end),
        .frame_end(frame_end),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic d;
        int   x;
        int   y;
        logic le;
        logic fe;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t last = '{d: 1'b0, x: 0, y: 0, le: 1'b0, fe: 1'b0};
    exp_t mon_e;
    int   ena_cnt = 0;

    // Model: 0 idle, 1 streaming, 2 done; n = pixels accepted so far in the frame.
    int mstate = 0;
    int n = 0;
    int mthresh = 128;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pix_ready"}, int'(pix_ready), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_d_out"}, int'(d_out), 0);
        chk({tag, "_ena"}, int'(ena), 0);
        chk({tag, "_x_pos"}, int'(x_pos), 0);
        chk({tag, "_y_pos"}, int'(y_pos), 0);
        chk({tag, "_line_end"}, int'(line_end), 0);
        chk({tag, "_frame_end"}, int'(frame_end), 0);
    endtask

    function automatic logic [7:0] pick(input int mode, input int idx);
        int t;
        case (mode)
            1: return 8'(idx);
            2: begin
                if (idx == 0) return 8'd127;
                if (idx == 1) return 8'd128;
                return 8'($urandom_range(0, 255));
            end
            3: begin
                t = mthresh - 2 + int'($urandom_range(0, 3));
                if (t < 0) t = 0;
                if (t > 255) t = 255;
                return 8'(t);
            end
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // One clock: check state-derived outputs, apply inputs, advance the model, wait the edge.
    task automatic cycle(input logic v, input logic [7:0] p, input logic s, input logic tl,
                         input logic [7:0] tv);
        @(negedge clk);
        chk("pix_ready", int'(pix_ready), int'(mstate == 1));
        chk("busy", int'(busy), int'(mstate != 0));
        pix_valid = v;
        pix_in    = p;
        start     = s;
        thresh_ld = tl;
        thresh_in = tv;
        if (mstate == 0) begin
            if (tl) mthresh = int'(tv);
            if (s) begin
                mstate = 1;
                n = 0;
            end
        end else if (mstate == 1) begin
            if (v) begin
                q.push_back('{d: (int'(p) >= mthresh), x: n % W, y: n / W,
                              le: ((n % W) == W - 1), fe: (n == W * H - 1)});
                n++;
                if (n == W * H) mstate = 2;
            end
        end else begin
            mstate = 0;
        end
        @(posedge clk);
    endtask

    task automatic run_frame(input int mode, input logic tl, input logic [7:0] tv,
                             input int stall_pct, input logic inject);
        logic injected;
        logic v;
        logic s;
        logic il;
        injected = 1'b0;
        ena_cnt = 0;
        cycle(1'b0, 8'd0, 1'b1, tl, tv);
        for (int c = 0; c < 500 && mstate != 0; c++) begin
            v  = (int'($urandom_range(0, 99)) >= stall_pct);
            s  = 1'b0;
            il = 1'b0;
            if (inject && !injected && mstate == 1 && n == 5) begin
                s = 1'b1;
                il = 1'b1;
                injected = 1'b1;
            end
            cycle(v, pick(mode, n), s, il, 8'd200);
        end
        if (mstate != 0) begin
            chk("frame_timeout", mstate, 0);
            mstate = 0;
        end
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
        chk("ena_count", ena_cnt, W * H);
        chk("queue_drained", q.size(), 0);
    endtask

    // Monitor: sample 2 time units after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                if (ena) ena_cnt++;
                if (q.size() > 0) begin
                    mon_e = q.pop_front();
                    chk("ena", int'(ena), 1);
                    chk("d_out", int'(d_out), int'(mon_e.d));
                    chk("x_pos", int'(x_pos), mon_e.x);
                    chk("y_pos", int'(y_pos), mon_e.y);
                    chk("line_end", int'(line_end), int'(mon_e.le));
                    chk("frame_end", int'(frame_end), int'(mon_e.fe));
                    last = mon_e;
                end else begin
                    chk("ena_idle", int'(ena), 0);
                    chk("line_end_idle", int'(line_end), 0);
                    chk("frame_end_idle", int'(frame_end), 0);
                    chk("d_out_hold", int'(d_out), int'(last.d));
                    chk("x_pos_hold", int'(x_pos), last.x);
                    chk("y_pos_hold", int'(y_pos), last.y);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Default threshold 128: pixel 127 -> 0, pixel 128 -> 1.
        run_frame(2, 1'b0, 8'd0, 0, 1'b0);
        // Sequential pixels 0..11 with threshold 6, no stalls.
        run_frame(1, 1'b1, 8'd6, 0, 1'b0);
        // Random stalls with a random threshold.
        run_frame(0, 1'b1, 8'($urandom_range(0, 255)), 50, 1'b0);
        run_frame(3, 1'b1, 8'd90, 40, 1'b0);
        // Mid-frame start/thresh_ld(200) must be ignored.
        run_frame(3, 1'b0, 8'd0, 30, 1'b1);
        // thresh_ld together with start in IDLE takes effect for that frame.
        run_frame(3, 1'b1, 8'd200, 20, 1'b0);
        run_frame(3, 1'b1, 8'd0, 20, 1'b0);
        run_frame(3, 1'b1, 8'd255, 20, 1'b0);

        // Asynchronous reset after 5 transfers.
        cycle(1'b0, 8'd0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        pix_valid = 1'b0;
        #1;
        chk_all_zero("midreset");
        q.delete();
        mstate = 0;
        n = 0;
        mthresh = 128;
        last = '{d: 1'b0, x: 0, y: 0, le: 1'b0, fe: 1'b0};
        @(negedge clk);
        rst = 1'b1;
        run_frame(2, 1'b0, 8'd0, 25, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
